// File: rtl/cpu_pkg.sv
// Shared syscall service codes and responder FSM state type.
package cpu_pkg;

  localparam logic [31:0] SVC_PRINT_INT  = 32'd1;
  localparam logic [31:0] SVC_EXIT       = 32'd10;
  localparam logic [31:0] SVC_PRINT_CHAR = 32'd11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } sc_state_e;

endpackage

// File: rtl/syscall_char_fifo.sv
// First-word fall-through byte FIFO; push is refused while full, pop while empty.
module syscall_char_fifo #(
  parameter  int DEPTH = 8,
  parameter  int W     = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty,
  output logic [AW:0]  o_count
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  // Full is taken from the registered count, so a same-cycle pop never makes room.
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_dout  = o_empty ? '0 : r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/syscall_responder.sv
// Executes CPU syscalls (print_int, print_char, exit) and streams printed bytes out.
// Optional: define SYSCALL_ERRCNT_EN to count accepted unknown service codes.
module syscall_responder
  import cpu_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter bit HEX_UPPER  = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sc_valid,
  input  logic [31:0]                   sc_v0,
  input  logic [31:0]                   sc_a0,
  output logic                          sc_ready,
  output logic                          out_valid,
  output logic [7:0]                    out_data,
  input  logic                          out_ready,
  output logic [31:0]                   hex_out,
  output logic                          halted,
  output logic [15:0]                   err_count,
  output sc_state_e                     dbg_state,
  output logic [2:0]                    dbg_nib_idx,
  output logic [$clog2(FIFO_DEPTH):0]   dbg_fifo_count
);

  sc_state_e   r_state;
  sc_state_e   w_state_nxt;
  logic [2:0]  r_nib_idx;
  logic [31:0] r_a0;
  logic [31:0] r_hex_out;
  logic        r_halted;
  logic        w_accept;
  logic        w_push;
  logic [7:0]  w_push_data;
  logic        w_fifo_full;
  logic        w_fifo_empty;
  logic [3:0]  w_nib;

  function automatic logic [7:0] nib_to_ascii(input logic [3:0] n);
    if (n < 4'd10) begin
      return 8'h30 + {4'h0, n};
    end
    return (HEX_UPPER ? 8'h37 : 8'h57) + {4'h0, n};
  endfunction

  // Handshakes: a transfer happens on a rising edge where valid && ready; the
  // producer holds valid and payload stable until that edge, ready never waits on valid.
  assign sc_ready  = (r_state == ST_IDLE) && !w_fifo_full && !r_halted;
  assign w_accept  = sc_valid && sc_ready;
  assign out_valid = !w_fifo_empty;
  assign w_nib     = r_a0[{r_nib_idx, 2'b00} +: 4];

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_push_data = 8'h00;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (sc_v0 == SVC_PRINT_INT) begin
            w_state_nxt = ST_EMIT;
          end else if (sc_v0 == SVC_PRINT_CHAR) begin
            w_push      = 1'b1;
            w_push_data = sc_a0[7:0];
          end
        end
      end
      ST_EMIT: begin
        if (!w_fifo_full) begin
          w_push      = 1'b1;
          w_push_data = nib_to_ascii(w_nib);
          if (r_nib_idx == 3'd0) begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_nib_idx <= 3'd7;
      r_a0      <= '0;
      r_hex_out <= '0;
      r_halted  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && w_accept) begin
        if (sc_v0 == SVC_PRINT_INT) begin
          r_hex_out <= sc_a0;
          r_a0      <= sc_a0;
          r_nib_idx <= 3'd7;
        end else if (sc_v0 == SVC_EXIT) begin
          r_halted <= 1'b1;
        end
      end else if (r_state == ST_EMIT && w_push) begin
        // Wraps 0 -> 7, leaving the index ready for the next print.
        r_nib_idx <= r_nib_idx - 1'b1;
      end
    end
  end

`ifdef SYSCALL_ERRCNT_EN
  logic [15:0] r_err_count;
  logic        w_unknown;

  assign w_unknown = w_accept && (sc_v0 != SVC_PRINT_INT) &&
                     (sc_v0 != SVC_PRINT_CHAR) && (sc_v0 != SVC_EXIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_count <= '0;
    end else if (w_unknown && (r_err_count != 16'hFFFF)) begin
      r_err_count <= r_err_count + 16'd1;
    end
  end

  assign err_count = r_err_count;
`else
  assign err_count = 16'h0;
`endif

  syscall_char_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   (w_push_data),
    .i_pop   (out_ready),
    .o_dout  (out_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (dbg_fifo_count)
  );

  assign hex_out     = r_hex_out;
  assign halted      = r_halted;
  assign dbg_state   = r_state;
  assign dbg_nib_idx = r_nib_idx;

endmodule
